balance_ledger: RTL and testbench

//  Key/value balance store directly downstream of the byte-packet command decoders (issue/transfer).

---
 rtl/ledger_pkg.sv | 22 ++
 rtl/ledger_table.sv | 28 ++
 rtl/balance_ledger.sv | 204 ++++++++++++++++++++
 tb/tb_balance_ledger.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledger_pkg.sv
// Shared command codes, status codes and FSM state encoding for the balance ledger.
package ledger_pkg;

    localparam logic [1:0] SIG_NOP      = 2'd0;
    localparam logic [1:0] SIG_QUERY    = 2'd1;
    localparam logic [1:0] SIG_TRANSACT = 2'd2;
    localparam logic [1:0] SIG_CLEAR    = 2'd3;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_NOT_FOUND    = 3'd1;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd2;
    localparam logic [2:0] ST_FULL         = 3'd3;
    localparam logic [2:0] ST_OVERFLOW     = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_UPDATE = 2'd2,
        S_RESP   = 2'd3
    } ledger_state_e;

endpackage

// File: rtl/ledger_table.sv
// DEPTH x (key,balance) register array: one asynchronous read port, one synchronous write port.
module ledger_table #(
    parameter int DEPTH = 16,
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int W    = KEY_W + VAL_W
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    output logic [W-1:0]  rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[idx];

    // Contents are not reset; entry_count in the parent defines which rows are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/balance_ledger.sv
// Key/value balance store: sequential table scan, then credit/debit/query/clear with a status response.
// Define LEDGER_TRACE_EN to print each response (simulation only).
module balance_ledger
    import ledger_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int KEY_W  = 32,
    parameter int VAL_W  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             tick_in,
    input  logic             rst_in,
    // Handshake: a command is accepted on a tick_in edge where req_valid & req_ready; req_ready is high only in IDLE.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       signal,
    input  logic [KEY_W-1:0] key,
    input  logic             transact_kind,
    input  logic [VAL_W-1:0] transact_value,
    output logic             resp_valid,
    output logic [2:0]       resp_status,
    output logic [KEY_W-1:0] resp_key,
    output logic [VAL_W-1:0] resp_balance,
    output logic [CNT_W-1:0] entry_count,
    output ledger_state_e    state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    ledger_state_e    state;
    logic [1:0]       cmd_sig;
    logic [KEY_W-1:0] cmd_key;
    logic             cmd_kind;
    logic [VAL_W-1:0] cmd_value;
    logic [CNT_W-1:0] idx;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [VAL_W-1:0] hit_bal;

    logic [KEY_W+VAL_W-1:0] rdata;
    logic [KEY_W-1:0]       rd_key;
    logic [VAL_W-1:0]       rd_val;
    logic                   match;
    logic                   last;

    logic [VAL_W:0]         sum;
    logic [2:0]             upd_status;
    logic [VAL_W-1:0]       upd_bal;
    logic                   upd_we;
    logic                   upd_alloc;
    logic [IDX_W-1:0]       upd_waddr;
    logic [KEY_W+VAL_W-1:0] upd_wdata;

    assign req_ready = (state == S_IDLE);
    assign state_dbg = state;

    assign rd_key = rdata[KEY_W+VAL_W-1:VAL_W];
    assign rd_val = rdata[VAL_W-1:0];
    assign match  = (idx < entry_count) && (rd_key == cmd_key);
    // Miss is decided while examining the last live entry, so an empty table still takes one scan cycle.
    assign last   = (idx + CNT_ONE) >= entry_count;

    ledger_table #(
        .DEPTH(DEPTH),
        .KEY_W(KEY_W),
        .VAL_W(VAL_W)
    ) u_table (
        .clk   (tick_in),
        .idx   (idx[IDX_W-1:0]),
        .rdata (rdata),
        .we    (upd_we && (state == S_UPDATE)),
        .waddr (upd_waddr),
        .wdata (upd_wdata)
    );

    assign sum = {1'b0, hit_bal} + {1'b0, cmd_value};

    always_comb begin
        upd_status = ST_OK;
        upd_bal    = hit_bal;
        upd_we     = 1'b0;
        upd_alloc  = 1'b0;
        upd_waddr  = hit_idx;
        upd_wdata  = {cmd_key, cmd_value};
        if (cmd_sig == SIG_QUERY) begin
            if (!hit) begin
                upd_status = ST_NOT_FOUND;
                upd_bal    = '0;
            end
        end else if (cmd_kind) begin
            if (hit) begin
                if (sum[VAL_W]) begin
                    upd_status = ST_OVERFLOW;
                end else begin
                    upd_bal   = sum[VAL_W-1:0];
                    upd_we    = 1'b1;
                    upd_wdata = {cmd_key, sum[VAL_W-1:0]};
                end
            end else if (entry_count < CNT_MAX) begin
                upd_bal   = cmd_value;
                upd_we    = 1'b1;
                upd_alloc = 1'b1;
                upd_waddr = entry_count[IDX_W-1:0];
            end else begin
                upd_status = ST_FULL;
                upd_bal    = '0;
            end
        end else begin
            if (!hit) begin
                upd_status = ST_NOT_FOUND;
                upd_bal    = '0;
            end else if (cmd_value > hit_bal) begin
                upd_status = ST_INSUFFICIENT;
            end else begin
                upd_bal   = hit_bal - cmd_value;
                upd_we    = 1'b1;
                upd_wdata = {cmd_key, hit_bal - cmd_value};
            end
        end
    end

    always_ff @(posedge tick_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            entry_count  <= '0;
            resp_valid   <= 1'b0;
            resp_status  <= ST_OK;
            resp_key     <= '0;
            resp_balance <= '0;
            cmd_sig      <= SIG_NOP;
            cmd_key      <= '0;
            cmd_kind     <= 1'b0;
            cmd_value    <= '0;
            idx          <= '0;
            hit          <= 1'b0;
            hit_idx      <= '0;
            hit_bal      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cmd_sig   <= signal;
                        cmd_key   <= key;
                        cmd_kind  <= transact_kind;
                        cmd_value <= transact_value;
                        idx       <= '0;
                        hit       <= 1'b0;
                        if (signal == SIG_QUERY || signal == SIG_TRANSACT) begin
                            state <= S_SEARCH;
                        end else if (signal == SIG_CLEAR) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_SEARCH: begin
                    if (match) begin
                        hit     <= 1'b1;
                        hit_idx <= idx[IDX_W-1:0];
                        hit_bal <= rd_val;
                        state   <= S_UPDATE;
                    end else if (last) begin
                        state <= S_UPDATE;
                    end else begin
                        idx <= idx + CNT_ONE;
                    end
                end
                S_UPDATE: begin
                    resp_valid   <= 1'b1;
                    resp_status  <= upd_status;
                    resp_key     <= cmd_key;
                    resp_balance <= upd_bal;
                    if (upd_alloc) begin
                        entry_count <= entry_count + CNT_ONE;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    // CLEAR responds here; scan commands already responded on entry to RESP.
                    if (cmd_sig == SIG_CLEAR) begin
                        entry_count  <= '0;
                        resp_valid   <= 1'b1;
                        resp_status  <= ST_OK;
                        resp_key     <= cmd_key;
                        resp_balance <= '0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LEDGER_TRACE_EN
    always @(posedge tick_in) begin
        if (resp_valid) begin
            $display("Key %d status %d new balance %d", resp_key, resp_status, resp_balance);
        end
    end
`endif

endmodule

// File: tb/tb_balance_ledger.sv
// Directed bench for balance_ledger: table model with expected-response queue, plus literal spot checks.
module tb_balance_ledger;
    import ledger_pkg::*;

    localparam int DEPTH = 16;
    localparam int KEY_W = 32;
    localparam int VAL_W = 32;
    localparam int CNT_W = 5;
    localparam int EW    = 32 + 3 + KEY_W + VAL_W + CNT_W;

    logic             tick_in;
    logic             rst_in;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       signal;
    logic [KEY_W-1:0] key;
    logic             transact_kind;
    logic [VAL_W-1:0] transact_value;
    logic             resp_valid;
    logic [2:0]       resp_status;
    logic [KEY_W-1:0] resp_key;
    logic [VAL_W-1:0] resp_balance;
    logic [CNT_W-1:0] entry_count;
    ledger_state_e    state_dbg;

    balance_ledger #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .tick_in        (tick_in),
        .rst_in         (rst_in),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .signal         (signal),
        .key            (key),
        .transact_kind  (transact_kind),
        .transact_value (transact_value),
        .resp_valid     (resp_valid),
        .resp_status    (resp_status),
        .resp_key       (resp_key),
        .resp_balance   (resp_balance),
        .entry_count    (entry_count),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial tick_in = 1'b0;
    always #5 tick_in = ~tick_in;

    int cyc = 0;
    always @(posedge tick_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // model state
    logic [KEY_W-1:0] m_key [DEPTH];
    logic [VAL_W-1:0] m_bal [DEPTH];
    int               m_cnt = 0;

    // expected responses: {due cycle, status, key, balance, count}
    logic [EW-1:0] exp_q[$];

    int         last_cyc = 0;
    logic [2:0] last_status = '0;
    logic [VAL_W-1:0] last_bal = '0;

    function automatic void model_apply(input logic [1:0] s, input logic [KEY_W-1:0] k,
                                        input logic kind, input logic [VAL_W-1:0] v,
                                        output int lat, output logic [2:0] st,
                                        output logic [VAL_W-1:0] bal);
        int h;
        h   = -1;
        st  = ST_OK;
        bal = '0;
        if (s == SIG_CLEAR) begin
            m_cnt = 0;
            lat   = 1;
            return;
        end
        for (int i = 0; i < m_cnt; i++) begin
            if (m_key[i] == k) h = i;
        end
        lat = (h >= 0) ? h + 2 : ((m_cnt > 1) ? m_cnt : 1) + 1;
        if (s == SIG_QUERY) begin
            if (h >= 0) bal = m_bal[h];
            else st = ST_NOT_FOUND;
        end else if (kind) begin
            if (h >= 0) begin
                if (longint'(m_bal[h]) + longint'(v) > 64'h0000_0000_FFFF_FFFF) begin
                    st  = ST_OVERFLOW;
                    bal = m_bal[h];
                end else begin
                    m_bal[h] = m_bal[h] + v;
                    bal      = m_bal[h];
                end
            end else if (m_cnt < DEPTH) begin
                m_key[m_cnt] = k;
                m_bal[m_cnt] = v;
                m_cnt++;
                bal = v;
            end else begin
                st = ST_FULL;
            end
        end else begin
            if (h < 0) begin
                st = ST_NOT_FOUND;
            end else if (v > m_bal[h]) begin
                st  = ST_INSUFFICIENT;
                bal = m_bal[h];
            end else begin
                m_bal[h] = m_bal[h] - v;
                bal      = m_bal[h];
            end
        end
    endfunction

    task automatic push_exp(input logic [1:0] s, input logic [KEY_W-1:0] k, input logic kind,
                            input logic [VAL_W-1:0] v, input int e0, output int lat);
        logic [2:0]       st;
        logic [VAL_W-1:0] bal;
        model_apply(s, k, kind, v, lat, st, bal);
        exp_q.push_back({32'(e0 + lat), st, k, bal, CNT_W'(m_cnt)});
    endtask

    // scoreboard: every cycle either the head expectation is due, or resp_valid must be low
    always @(negedge tick_in) begin
        logic [EW-1:0]    e;
        logic [2:0]       e_st;
        logic [KEY_W-1:0] e_key;
        logic [VAL_W-1:0] e_bal;
        logic [CNT_W-1:0] e_cnt;
        if (exp_q.size() != 0 && int'(exp_q[0][EW-1:EW-32]) == cyc) begin
            e     = exp_q.pop_front();
            e_st  = e[EW-33:EW-35];
            e_key = e[KEY_W+VAL_W+CNT_W-1:VAL_W+CNT_W];
            e_bal = e[VAL_W+CNT_W-1:CNT_W];
            e_cnt = e[CNT_W-1:0];
            checks++;
            if (!(resp_valid === 1'b1 && resp_status === e_st && resp_key === e_key &&
                  resp_balance === e_bal && entry_count === e_cnt)) begin
                errors++;
                $display("FAIL resp cyc=%0d got v=%0b st=%0d key=%0d bal=%0d cnt=%0d want st=%0d key=%0d bal=%0d cnt=%0d",
                         cyc, resp_valid, resp_status, resp_key, resp_balance, entry_count,
                         e_st, e_key, e_bal, e_cnt);
            end
            last_cyc    = cyc;
            last_status = resp_status;
            last_bal    = resp_balance;
        end else if (resp_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected cyc=%0d got v=%0b st=%0d key=%0d want v=0",
                     cyc, resp_valid, resp_status, resp_key);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // driver: waits for IDLE, presents one command for exactly one accept edge
    task automatic send(input logic [1:0] s, input logic [KEY_W-1:0] k, input logic kind,
                        input logic [VAL_W-1:0] v, input bit expect_resp, output int e0);
        int n;
        int lat;
        n = 0;
        @(negedge tick_in);
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge tick_in);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got %0b want 1", req_ready);
        end
        signal         = s;
        key            = k;
        transact_kind  = kind;
        transact_value = v;
        req_valid      = 1'b1;
        @(posedge tick_in);
        #1;
        e0        = cyc;
        req_valid = 1'b0;
        if (expect_resp && s != SIG_NOP) push_exp(s, k, kind, v, e0, lat);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge tick_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got cyc=%0d want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int lat;
        int busy_to;
        int accepts;
        bit exp_rdy;

        rst_in         = 1'b1;
        req_valid      = 1'b0;
        signal         = SIG_NOP;
        key            = '0;
        transact_kind  = 1'b0;
        transact_value = '0;
        repeat (3) @(negedge tick_in);
        rst_in = 1'b0;
        @(negedge tick_in);
        check_lit("rst_ready", 32'(req_ready), 1);
        check_lit("rst_resp_valid", 32'(resp_valid), 0);
        check_lit("rst_status", 32'(resp_status), 0);
        check_lit("rst_key", resp_key, 0);
        check_lit("rst_balance", resp_balance, 0);
        check_lit("rst_count", 32'(entry_count), 0);

        // 1: query on empty table
        send(SIG_QUERY, 5, 0, 0, 1, e0);
        wait_done();
        check_lit("t1_latency", 32'(last_cyc - e0), 2);
        check_lit("t1_status", 32'(last_status), 1);

        // 2: two allocations, query of second entry
        send(SIG_TRANSACT, 7, 1, 100, 1, e0);
        send(SIG_NOP, 3, 1, 1, 1, e0);
        send(SIG_TRANSACT, 9, 1, 50, 1, e0);
        send(SIG_QUERY, 9, 0, 0, 1, e0);
        wait_done();
        check_lit("t2_latency", 32'(last_cyc - e0), 3);
        check_lit("t2_balance", last_bal, 50);
        check_lit("t2_count", 32'(entry_count), 2);

        // 3: debits
        send(SIG_TRANSACT, 7, 0, 101, 1, e0);
        wait_done();
        check_lit("t3_insuff_status", 32'(last_status), 2);
        check_lit("t3_insuff_balance", last_bal, 100);
        send(SIG_TRANSACT, 7, 0, 100, 1, e0);
        wait_done();
        check_lit("t3_debit_balance", last_bal, 0);
        send(SIG_TRANSACT, 77, 0, 5, 1, e0);

        // 4: overflow boundary and table full
        send(SIG_TRANSACT, 7, 1, 1, 1, e0);
        send(SIG_TRANSACT, 7, 1, 32'hFFFF_FFFF, 1, e0);
        wait_done();
        check_lit("t4_ovf_status", 32'(last_status), 4);
        check_lit("t4_ovf_balance", last_bal, 1);
        send(SIG_TRANSACT, 7, 1, 32'hFFFF_FFFE, 1, e0);
        wait_done();
        check_lit("t4_max_balance", last_bal, 32'hFFFF_FFFF);
        for (int i = 0; i <= DEPTH; i++) begin
            send(SIG_TRANSACT, 32'(100 + i), 1, 32'(i + 1), 1, e0);
        end
        wait_done();
        check_lit("t4_full_status", 32'(last_status), 3);
        check_lit("t4_full_count", 32'(entry_count), DEPTH);

        // 5: req_valid held high across whole transactions
        busy_to = -1;
        accepts = 0;
        @(negedge tick_in);
        signal         = SIG_QUERY;
        key            = 9;
        transact_kind  = 1'b0;
        transact_value = '0;
        req_valid      = 1'b1;
        for (int c = 0; c < 15; c++) begin
            exp_rdy = (cyc > busy_to);
            check_lit("t5_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                push_exp(SIG_QUERY, 9, 0, 0, cyc + 1, lat);
                busy_to = cyc + 1 + lat;
                accepts++;
            end
            @(negedge tick_in);
        end
        req_valid = 1'b0;
        check_lit("t5_accepts", 32'(accepts), 3);
        wait_done();

        // 6: reset during a scan, then clear
        send(SIG_QUERY, 999, 0, 0, 0, e0);
        repeat (3) @(negedge tick_in);
        rst_in = 1'b1;
        @(negedge tick_in);
        rst_in = 1'b0;
        m_cnt  = 0;
        check_lit("t6_rst_count", 32'(entry_count), 0);
        check_lit("t6_rst_ready", 32'(req_ready), 1);
        repeat (25) @(negedge tick_in);
        send(SIG_TRANSACT, 1, 1, 10, 1, e0);
        send(SIG_TRANSACT, 2, 1, 20, 1, e0);
        send(SIG_TRANSACT, 3, 1, 30, 1, e0);
        send(SIG_CLEAR, 55, 0, 0, 1, e0);
        wait_done();
        check_lit("t6_clear_latency", 32'(last_cyc - e0), 1);
        check_lit("t6_clear_count", 32'(entry_count), 0);
        send(SIG_QUERY, 2, 0, 0, 1, e0);
        wait_done();
        check_lit("t6_query_status", 32'(last_status), 1);
        send(SIG_TRANSACT, 4, 1, 0, 1, e0);
        send(SIG_TRANSACT, 8, 0, 5, 1, e0);
        send(SIG_QUERY, 4, 0, 0, 1, e0);
        wait_done();
        check_lit("t6_zero_count", 32'(entry_count), 1);

        repeat (3) @(negedge tick_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
